// File: rtl/nic_pkg.sv
// nic_pkg: shared NIC map, status flag position and scheduler enums
package nic_pkg;
  localparam int NIC_DW = 64;
  localparam int NIC_FULL_BIT = NIC_DW - 1;
  localparam logic [1:0] NIC_ADDR_IBUF  = 2'b00;
  localparam logic [1:0] NIC_ADDR_ISTAT = 2'b01;
  localparam logic [1:0] NIC_ADDR_OBUF  = 2'b10;
  localparam logic [1:0] NIC_ADDR_OSTAT = 2'b11;
  typedef enum logic [2:0] {
    IDLE, OSTAT_REQ, OSTAT_CHK, OBUF_WR, ISTAT_REQ, ISTAT_CHK, IBUF_REQ, IBUF_CAP
  } nic_sched_state_t;
  typedef enum logic {DIR_RX, DIR_TX} nic_dir_t;
endpackage

// File: rtl/nic_sched_rr_arbiter.sv
// rr_arbiter: first set request at or after ptr, wrapping
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx,
  output logic            any_req
);
  // scan from farthest to nearest so the nearest request at/after ptr wins
  always_comb begin
    grant_idx = '0;
    any_req = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        grant_idx = PW'((int'(ptr) + k) % NREQ);
        any_req = 1'b1;
      end
    end
    grant = any_req ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
  end
endmodule

// File: rtl/nic_sched.sv
// nic_sched: shares the NIC processor port between round-robin TX clients and one RX sink
module nic_sched
  import nic_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW = NIC_DW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sched_en,
  input  logic [NREQ-1:0]    tx_valid,
  input  logic [NREQ*DW-1:0] tx_data,
  output logic [NREQ-1:0]    tx_ready,
  output logic               rx_valid,
  output logic [DW-1:0]      rx_data,
  input  logic               rx_ready,
  output logic [1:0]         nic_addr,
  output logic [DW-1:0]      nic_d_in,
  output logic               nic_en,
  output logic               nic_en_wr,
  input  logic [DW-1:0]      nic_d_out
);
  localparam int PW = $clog2(NREQ);
  nic_sched_state_t state;
  nic_dir_t last_dir;
  logic [PW-1:0] rr_ptr, gidx_q, arb_idx;
  logic [NREQ-1:0] goh_q, arb_oh;
  logic arb_any;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(tx_valid), .ptr(rr_ptr), .grant(arb_oh), .grant_idx(arb_idx), .any_req(arb_any)
  );
  // NIC pins and tx_ready decoded straight from the state so async reset drops them at once
  always_comb begin
    nic_en = state inside {OSTAT_REQ, OBUF_WR, ISTAT_REQ, IBUF_REQ};
    nic_en_wr = state == OBUF_WR;
    nic_addr = state == OSTAT_REQ ? NIC_ADDR_OSTAT : state == OBUF_WR ? NIC_ADDR_OBUF :
               state == ISTAT_REQ ? NIC_ADDR_ISTAT : NIC_ADDR_IBUF;
    nic_d_in = nic_en_wr ? tx_data[gidx_q*DW +: DW] : '0;
    tx_ready = nic_en_wr ? goh_q : '0;
  end
  // polling FSM: pick a direction in IDLE, run one status/transfer round, return to IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last_dir <= DIR_RX;
      rr_ptr <= '0;
      gidx_q <= '0;
      goh_q <= '0;
      rx_valid <= 1'b0;
      rx_data <= '0;
    end else begin
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sched_en && arb_any && (rx_valid || last_dir == DIR_RX)) state <= OSTAT_REQ;
          else if (sched_en && !rx_valid) state <= ISTAT_REQ;
        end
        OSTAT_REQ: begin
          gidx_q <= arb_idx;
          goh_q <= arb_oh;
          state <= OSTAT_CHK;
        end
        OSTAT_CHK: begin
          last_dir <= DIR_TX;
          state <= nic_d_out[NIC_FULL_BIT] ? IDLE : OBUF_WR;
        end
        OBUF_WR: begin
          rr_ptr <= gidx_q == PW'(NREQ - 1) ? '0 : gidx_q + 1'b1;
          state <= IDLE;
        end
        ISTAT_REQ: state <= ISTAT_CHK;
        ISTAT_CHK: begin
          last_dir <= DIR_RX;
          state <= nic_d_out[NIC_FULL_BIT] ? IBUF_REQ : IDLE;
        end
        IBUF_REQ: state <= IBUF_CAP;
        IBUF_CAP: begin
          rx_data <= nic_d_out;
          rx_valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/nic_sched.md
# nic_sched

Processor-side scheduler for one `nic_mesh` instance. It shares the NIC's single processor port between NREQ transmit clients and one receive sink. It polls the NIC status registers, writes the output channel buffer for a round-robin-selected client when that buffer is empty, and drains the input channel buffer into a holding register when that buffer is full. It sits between the core/DMA clients and the `nic_mesh` `addr`/`d_in`/`nicEn`/`nicEnWr`/`d_out` pins.

## Interface
Parameters:
- NREQ, 4, number of transmit clients (2..8)
- DW, 64, data width; must equal the NIC data width

Ports:
- clk  in  1  single clock; all logic rising-edge
- reset  in  1  asynchronous, active-low reset
- sched_en  in  1  1 = scheduling allowed; 0 = FSM stays in IDLE once the current access completes
- tx_valid  in  [0:NREQ-1]  client i has a packet; held until its tx_ready pulse
- tx_data  in  [0:NREQ*DW-1]  client i occupies bits [i*DW : i*DW+DW-1]
- tx_ready  out  [0:NREQ-1]  one-cycle pulse; the packet of the granted client is consumed that cycle
- rx_valid  out  1  rx_data holds an unconsumed packet
- rx_data  out  [0:DW-1]  packet read from the NIC input channel buffer
- rx_ready  in  1  sink accepts; transfer occurs when rx_valid & rx_ready
- nic_addr  out  [0:1]  to NIC addr
- nic_d_in  out  [0:DW-1]  to NIC d_in
- nic_en  out  1  to NIC nicEn
- nic_en_wr  out  1  to NIC nicEnWr
- nic_d_out  in  [0:DW-1]  from NIC d_out

## Operation
- NIC map: 00 = input buffer, 01 = input status, 10 = output buffer, 11 = output status. Status full flag is bit DW-1 of nic_d_out (1 = full).
- NIC read data is valid on nic_d_out in the cycle after the read-command cycle.
- FSM states: IDLE, OSTAT_REQ, OSTAT_CHK, OBUF_WR, ISTAT_REQ, ISTAT_CHK, IBUF_REQ, IBUF_CAP.
- Candidates:
  - The TX candidate exists when any tx_valid is set.
  - The RX candidate exists when rx_valid = 0.
- IDLE with sched_en = 1:
  - If only one candidate exists, take that direction.
  - If both exist, take the direction opposite to last_dir.
  - If neither exists, stay in IDLE.
- TX path:
  - OSTAT_REQ drives addr 11, en 1, wr 0.
  - OSTAT_CHK: if the full bit is 0, go to OBUF_WR; otherwise go to IDLE. last_dir is set to TX either way.
  - OBUF_WR drives addr 10, en 1, wr 1, and nic_d_in = data of the granted client. It pulses that client's tx_ready and advances rr_ptr to grant+1 modulo NREQ. Next state is IDLE.
- Grant: computed in OSTAT_REQ as the first set tx_valid at or after rr_ptr, wrapping, and held through OBUF_WR.
- RX path:
  - ISTAT_REQ drives addr 01, en 1, wr 0.
  - ISTAT_CHK: if the full bit is 1, go to IBUF_REQ; otherwise go to IDLE. last_dir is set to RX either way.
  - IBUF_REQ drives addr 00, en 1, wr 0.
  - IBUF_CAP loads rx_data from nic_d_out and sets rx_valid. Next state is IDLE.
- rx_valid clears on the cycle after rx_valid & rx_ready. rx_data holds its value until the next capture.
- In every state other than OSTAT_REQ, OBUF_WR, ISTAT_REQ and IBUF_REQ: nic_en = 0, nic_en_wr = 0, nic_addr = 00, nic_d_in = 0.
- Clients must not drop tx_valid before tx_ready. If a client drops it anyway, the held grant still writes that client's current tx_data.

## Timing
- NIC-side outputs and tx_ready are decoded from the state register. Each is asserted for exactly the cycle spent in its state.
- TX latency: tx_valid seen in IDLE at cycle 0 → OSTAT_REQ at 1 → OSTAT_CHK at 2 → OBUF_WR / tx_ready at 3 → IDLE at 4.
- RX latency: IDLE at 0 → ISTAT_REQ at 1 → ISTAT_CHK at 2 → IBUF_REQ at 3 → IBUF_CAP at 4 → rx_valid high from cycle 5.
- At most one NIC access per cycle. There is no back-to-back overlap; every round returns to IDLE.
- sched_en is sampled only in IDLE. Clearing it mid-round does not abort the round.
- Reset, asynchronous on reset = 0:
  - state = IDLE, rr_ptr = 0, last_dir = RX (so TX is first when both directions are pending)
  - rx_valid = 0, rx_data = 0, tx_ready = 0
  - all NIC-side outputs 0
  - These apply immediately, even mid-access. A write aborted this way is not retried, and its tx_ready never pulses.
- Output buffer full: no write occurs and no tx_ready is pulsed. The client is retried on a later round.
- Input buffer empty: no read of addr 00 is issued.

## Structure
- Shared package nic_pkg holds:
  - address constants NIC_ADDR_IBUF/ISTAT/OBUF/OSTAT
  - NIC_FULL_BIT
  - the nic_sched_state_t enum
  - the direction enum used for last_dir
- One sub-module, rr_arbiter (NREQ): inputs req vector and ptr; outputs one-hot grant, grant index and any_req. It is instantiated once.

## Test plan
- Single TX: reset, client 2 tx_valid with data 32, status full = 0 → cycle 3 has addr 10, en 1, wr 1, nic_d_in = 32, and tx_ready = 0010.
- Round-robin: clients 0, 1 and 3 held valid, status always empty → grant order 0, 1, 3, 0; each tx_ready pulses exactly once per round.
- Full output buffer: status bit 63 = 1 → OSTAT polled repeatedly, no wr = 1 cycle, tx_ready stays 0; clearing the bit → write occurs on the next TX round.
- RX capture: input status full, input buffer data 132, rx_ready = 0 → rx_valid = 1 and rx_data = 132; no further ISTAT poll until rx_ready pulses, after which rx_valid falls the next cycle.
- Alternation: TX valid and RX candidate both pending, both buffers ready → rounds alternate TX, RX, TX starting with TX.
- Async reset during OBUF_WR → en/wr/tx_ready drop without waiting for a clock edge; after release the first round is TX with rr_ptr = 0.
